mimo_sync_combiner: RTL and testbench



---
 rtl/msrx_pkg.sv | 18 +
 rtl/energy_sum_tree.sv | 50 +++++
 rtl/mimo_sync_combiner.sv | 150 +++++++++++++++
 tb/tb_mimo_sync_combiner.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msrx_pkg.sv
// Shared types and constants for the MIMO sync combiner: FSM state encoding,
// energy-sum width helper and the default detection threshold.
package msrx_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } sync_state_t;

  localparam int unsigned DEFAULT_THRESH = 32'd4000000;

  // One extra bit above clog2 keeps the half-sum comparison free of wrap concerns.
  function automatic int sw_width(input int n_ant, input int e_w);
    return e_w + $clog2(n_ant) + 1;
  endfunction

endpackage

// File: rtl/energy_sum_tree.sv
// Stage 1 of the combiner: masked, zero-extended per-antenna energy sums,
// registered together with their valid bit.
module energy_sum_tree #(
  parameter int N_ANT = 4,
  parameter int E_W   = 64,
  parameter int SW    = 67
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_ANT*E_W-1:0]   corr_energy,
  input  logic [N_ANT*E_W-1:0]   total_energy,
  input  logic                   energy_valid,
  input  logic [N_ANT-1:0]       ant_mask,
  output logic [SW-1:0]          sum_corr,
  output logic [SW-1:0]          sum_total,
  output logic                   sum_valid
);

  logic [SW-1:0] corr_acc;
  logic [SW-1:0] total_acc;

  // Accumulate every enabled antenna at full SW width so the sums cannot overflow.
  always_comb begin
    corr_acc  = {SW{1'b0}};
    total_acc = {SW{1'b0}};
    for (int i = 0; i < N_ANT; i++) begin
      if (ant_mask[i]) begin
        corr_acc  = corr_acc  + SW'(corr_energy[i*E_W +: E_W]);
        total_acc = total_acc + SW'(total_energy[i*E_W +: E_W]);
      end else begin
        corr_acc  = corr_acc;
        total_acc = total_acc;
      end
    end
  end

  // Stage-1 register; the valid bit is cleared by reset so in-flight samples are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_corr  <= {SW{1'b0}};
      sum_total <= {SW{1'b0}};
      sum_valid <= 1'b0;
    end else begin
      sum_corr  <= corr_acc;
      sum_total <= total_acc;
      sum_valid <= energy_valid;
    end
  end

endmodule

// File: rtl/mimo_sync_combiner.sv
// Multi-antenna sync detector: sum tree, hit decision and SEARCH/CONFIRM/LOCKED FSM.
// Optional per-antenna masking is enabled by defining MSRX_ANT_MASK_EN.
module mimo_sync_combiner
  import msrx_pkg::*;
#(
  parameter int N_ANT     = 4,
  parameter int E_W       = 64,
  parameter int CONFIRM_N = 4,
  parameter int LOSS_N    = 8,
  localparam int SW       = sw_width(N_ANT, E_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_ANT*E_W-1:0] corr_energy,
  input  logic [N_ANT*E_W-1:0] total_energy,
  input  logic                 energy_valid,
`ifdef MSRX_ANT_MASK_EN
  input  logic [N_ANT-1:0]     ant_mask,
`endif
  input  logic [SW-1:0]        energy_thresh,
  output logic                 sync_found,
  output logic [1:0]           sync_state,
  output logic                 lock_event,
  output logic                 loss_event,
  output logic [15:0]          lock_count
);

  logic [N_ANT-1:0] mask_eff;
  logic [SW-1:0]    sum_corr;
  logic [SW-1:0]    sum_total;
  logic             sum_valid;
  logic             hit;
  logic             hit_valid;
  sync_state_t      state;
  logic [7:0]       hit_cnt;
  logic [7:0]       miss_cnt;
  logic             lock_pend;
  logic             loss_pend;

`ifdef MSRX_ANT_MASK_EN
  assign mask_eff = ant_mask;
`else
  assign mask_eff = {N_ANT{1'b1}};
`endif

  energy_sum_tree #(.N_ANT(N_ANT), .E_W(E_W), .SW(SW)) u_sum (
    .clk          (clk),
    .rst          (rst),
    .corr_energy  (corr_energy),
    .total_energy (total_energy),
    .energy_valid (energy_valid),
    .ant_mask     (mask_eff),
    .sum_corr     (sum_corr),
    .sum_total    (sum_total),
    .sum_valid    (sum_valid)
  );

  // Stage 2: strict unsigned hit decision against the threshold present now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit       <= 1'b0;
      hit_valid <= 1'b0;
    end else begin
      hit       <= (sum_total > energy_thresh) && (sum_corr > (sum_total >> 1));
      hit_valid <= sum_valid;
    end
  end

  // Sync FSM; event flags are one-cycle and only set on an actual transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      hit_cnt   <= 8'd0;
      miss_cnt  <= 8'd0;
      lock_pend <= 1'b0;
      loss_pend <= 1'b0;
    end else begin
      lock_pend <= 1'b0;
      loss_pend <= 1'b0;
      case (state)
        SEARCH: begin
          if (hit_valid && hit) begin
            if (9'(CONFIRM_N) == 9'd1) begin
              state     <= LOCKED;
              hit_cnt   <= 8'd0;
              miss_cnt  <= 8'd0;
              lock_pend <= 1'b1;
            end else begin
              state   <= CONFIRM;
              hit_cnt <= 8'd1;
            end
          end
        end
        CONFIRM: begin
          if (hit_valid) begin
            if (!hit) begin
              state   <= SEARCH;
              hit_cnt <= 8'd0;
            end else if (({1'b0, hit_cnt} + 9'd1) >= 9'(CONFIRM_N)) begin
              state     <= LOCKED;
              hit_cnt   <= 8'd0;
              miss_cnt  <= 8'd0;
              lock_pend <= 1'b1;
            end else begin
              hit_cnt <= hit_cnt + 8'd1;
            end
          end
        end
        LOCKED: begin
          if (hit_valid) begin
            if (hit) begin
              miss_cnt <= 8'd0;
            end else if (({1'b0, miss_cnt} + 9'd1) >= 9'(LOSS_N)) begin
              state     <= SEARCH;
              miss_cnt  <= 8'd0;
              loss_pend <= 1'b1;
            end else begin
              miss_cnt <= miss_cnt + 8'd1;
            end
          end
        end
        default: begin
          state    <= SEARCH;
          hit_cnt  <= 8'd0;
          miss_cnt <= 8'd0;
        end
      endcase
    end
  end

  // Output register stage derived purely from the registered FSM state and events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_found <= 1'b0;
      sync_state <= 2'd0;
      lock_event <= 1'b0;
      loss_event <= 1'b0;
      lock_count <= 16'd0;
    end else begin
      sync_found <= (state == LOCKED);
      sync_state <= state;
      lock_event <= lock_pend;
      loss_event <= loss_pend;
      if (lock_pend && (lock_count != 16'hFFFF)) begin
        lock_count <= lock_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mimo_sync_combiner.sv
// Directed plus randomized bench for mimo_sync_combiner with a run-length reference model.
module tb_mimo_sync_combiner;
  import msrx_pkg::*;

  localparam int N_ANT     = 4;
  localparam int E_W       = 64;
  localparam int CONFIRM_N = 4;
  localparam int LOSS_N    = 8;
  localparam int SW        = sw_width(N_ANT, E_W);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_ANT*E_W-1:0] corr_energy;
  logic [N_ANT*E_W-1:0] total_energy;
  logic                 energy_valid;
  logic [N_ANT-1:0]     ant_mask;
  logic [SW-1:0]        energy_thresh;
  logic                 sync_found;
  logic [1:0]           sync_state;
  logic                 lock_event;
  logic                 loss_event;
  logic [15:0]          lock_count;

  always #5 clk = ~clk;

  mimo_sync_combiner #(.N_ANT(N_ANT), .E_W(E_W), .CONFIRM_N(CONFIRM_N), .LOSS_N(LOSS_N)) dut (
    .clk           (clk),
    .rst           (rst),
    .corr_energy   (corr_energy),
    .total_energy  (total_energy),
    .energy_valid  (energy_valid),
`ifdef MSRX_ANT_MASK_EN
    .ant_mask      (ant_mask),
`endif
    .energy_thresh (energy_thresh),
    .sync_found    (sync_found),
    .sync_state    (sync_state),
    .lock_event    (lock_event),
    .loss_event    (loss_event),
    .lock_count    (lock_count)
  );

  typedef struct packed {
    logic        found;
    logic [1:0]  st;
    logic        lev;
    logic        sev;
    logic [15:0] cnt;
  } exp_t;

  int            checks = 0;
  int            failures = 0;
  int            loss_seen;
  logic [E_W-1:0] corr_v [N_ANT];
  logic [E_W-1:0] tot_v  [N_ANT];
  logic [N_ANT-1:0] mask_v;
  logic [SW-1:0]  thr;
  bit             m_locked;
  int             m_run;
  int             m_count;
  exp_t           dly [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic bit ref_hit();
    logic [SW-1:0] sc;
    logic [SW-1:0] st;
    sc = '0;
    st = '0;
    for (int i = 0; i < N_ANT; i++) begin
      if (mask_v[i]) begin
        sc = sc + SW'(corr_v[i]);
        st = st + SW'(tot_v[i]);
      end
    end
    return (st > thr) && (sc > st / 2);
  endfunction

  // Model: consecutive hits while unlocked, consecutive misses while locked.
  task automatic model_apply(input bit v, input bit h, output exp_t e);
    e.lev = 1'b0;
    e.sev = 1'b0;
    if (v) begin
      if (!m_locked) begin
        m_run = h ? m_run + 1 : 0;
        if (m_run >= CONFIRM_N) begin
          m_locked = 1'b1;
          m_run = 0;
          e.lev = 1'b1;
          if (m_count < 65535) m_count++;
        end
      end else begin
        m_run = h ? 0 : m_run + 1;
        if (m_run >= LOSS_N) begin
          m_locked = 1'b0;
          m_run = 0;
          e.sev = 1'b1;
        end
      end
    end
    e.found = m_locked;
    e.st    = m_locked ? 2'd2 : ((m_run > 0) ? 2'd1 : 2'd0);
    e.cnt   = 16'(m_count);
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_run = 0;
    m_count = 0;
    for (int i = 0; i < 3; i++) dly[i] = '0;
  endtask

  task automatic step(input bit v);
    exp_t e;
    exp_t x;
    bit   h;
    energy_valid = v;
    for (int i = 0; i < N_ANT; i++) begin
      corr_energy[i*E_W +: E_W]  = corr_v[i];
      total_energy[i*E_W +: E_W] = tot_v[i];
    end
    ant_mask = mask_v;
    energy_thresh = thr;
    @(posedge clk);
    #1;
    h = ref_hit();
    model_apply(v, h, e);
    x = dly[2];
    check("sync_found", 32'(sync_found), 32'(x.found));
    check("sync_state", 32'(sync_state), 32'(x.st));
    check("lock_event", 32'(lock_event), 32'(x.lev));
    check("loss_event", 32'(loss_event), 32'(x.sev));
    check("lock_count", 32'(lock_count), 32'(x.cnt));
    if (loss_event) loss_seen++;
    dly[2] = dly[1];
    dly[1] = dly[0];
    dly[0] = e;
  endtask

  task automatic set_all(input logic [E_W-1:0] c, input logic [E_W-1:0] t);
    for (int i = 0; i < N_ANT; i++) begin
      corr_v[i] = c;
      tot_v[i]  = t;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic hits(input int n);
    set_all(64'd1500000, 64'd2000000);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  task automatic misses(input int n);
    set_all(64'd800000, 64'd900000);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  initial begin
    bit mode;
    rst = 1'b1;
    energy_valid = 1'b0;
    corr_energy = '0;
    total_energy = '0;
    mask_v = {N_ANT{1'b1}};
    ant_mask = mask_v;
    thr = SW'(DEFAULT_THRESH);
    energy_thresh = thr;
    set_all(64'd0, 64'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_found", 32'(sync_found), 32'd0);
    check("rst_state", 32'(sync_state), 32'd0);
    check("rst_count", 32'(lock_count), 32'd0);
    rst = 1'b0;

    // Four consecutive hits lock; the pulse appears three edges after the fourth.
    hits(4);
    idle(2);
    check("lock_pre_pulse", 32'(lock_event), 32'd0);
    idle(1);
    check("lock_035_found", 32'(sync_found), 32'd1);
    check("lock_035_event", 32'(lock_event), 32'd1);
    check("lock_035_count", 32'(lock_count), 32'd1);
    check("lock_035_state", 32'(sync_state), 32'd2);

    // Seven misses then a hit hold the lock; eight further misses drop it once.
    loss_seen = 0;
    misses(7);
    hits(1);
    idle(3);
    check("hold_037_found", 32'(sync_found), 32'd1);
    check("hold_037_noloss", 32'(loss_seen), 32'd0);
    misses(8);
    idle(3);
    check("loss_037_once", 32'(loss_seen), 32'd1);
    check("loss_037_found", 32'(sync_found), 32'd0);

    // Weak correlation on the third sample restarts the confirmation.
    hits(2);
    set_all(64'd900000, 64'd2000000);
    step(1'b1);
    hits(1);
    idle(3);
    check("abort_036_found", 32'(sync_found), 32'd0);
    check("abort_036_state", 32'(sync_state), 32'd1);
    hits(3);
    idle(3);
    check("relock_036_count", 32'(lock_count), 32'd2);
    misses(8);
    idle(3);

    // Strict boundaries: total equal to threshold and corr equal to half total miss.
    set_all(64'd1000000, 64'd1000000);
    step(1'b1);
    set_all(64'd625000, 64'd1250000);
    step(1'b1);
    set_all(64'd625001, 64'd1250000);
    step(1'b1);
    idle(3);
    check("bound_state", 32'(sync_state), 32'd1);
    misses(1);

    // Gapped valid stream still locks after four valid hits.
    set_all(64'd1500000, 64'd2000000);
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      step(1'b0);
    end
    idle(2);
    check("gap_038_found", 32'(sync_found), 32'd1);
    check("gap_038_count", 32'(lock_count), 32'd3);

    // Reset while locked clears everything at once without a loss pulse.
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_found", 32'(sync_found), 32'd0);
    check("rst_mid_loss", 32'(loss_event), 32'd0);
    check("rst_mid_state", 32'(sync_state), 32'd0);
    check("rst_mid_count", 32'(lock_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    hits(4);
    idle(3);
    check("relock_039_found", 32'(sync_found), 32'd1);
    check("relock_039_count", 32'(lock_count), 32'd1);

    // Full-scale energies: the sums need the extra width bits.
    set_all({E_W{1'b1}}, {E_W{1'b1}});
    step(1'b1);
    set_all(64'h8000000000000000, {E_W{1'b1}});
    step(1'b1);
    set_all(64'h7FFFFFFFFFFFFFFF, {E_W{1'b1}});
    step(1'b1);
    idle(3);

    // Randomized runs with sticky strong/weak modes so locks and losses both occur.
    mode = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(7, 0) == 0) mode = ~mode;
      for (int i = 0; i < N_ANT; i++) begin
        if (mode) begin
          tot_v[i]  = 64'($urandom_range(2000000, 1100000));
          corr_v[i] = 64'($urandom_range(32'(tot_v[i]), 32'(tot_v[i]) / 2));
        end else begin
          tot_v[i]  = 64'($urandom_range(2000000, 0));
          corr_v[i] = 64'($urandom_range(32'(tot_v[i]), 0));
        end
      end
      step($urandom_range(3, 0) != 0);
    end
    idle(3);

`ifdef MSRX_ANT_MASK_EN
    misses(8);
    idle(3);
    loss_seen = 0;
    mask_v = 4'b0001;
    set_all(64'd0, 64'd5000000);
    corr_v[0] = 64'd3000000;
    for (int i = 0; i < 4; i++) step(1'b1);
    idle(3);
    check("mask_lock_found", 32'(sync_found), 32'd1);
    mask_v = 4'b0000;
    for (int i = 0; i < LOSS_N; i++) step(1'b1);
    idle(3);
    check("mask_loss_once", 32'(loss_seen), 32'd1);
    check("mask_loss_found", 32'(sync_found), 32'd0);
    mask_v = {N_ANT{1'b1}};
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
